share_mask_feeder: RTL and testbench
====================================

// Module: share_mask_feeder
// PURPOSE
//  Upstream feeder for the masked PRINCE S-box pipeline (CMS share registers).
//  - Splits an unmasked nibble into NSHARES Boolean shares using an internal 16-bit LFSR.
//  - Presents the shares, registered, to the S-box share registers.
//  - Waits the S-box pipeline latency, then XOR-recombines the returned shares.
//  - Delivers the unmasked result over a valid/ready handshake.
//  - One transaction in flight at a time.
// PARAMETERS
//  DATA_W    4         width of one share / data nibble
//  NSHARES   2         number of shares; constraint (NSHARES-1)*DATA_W <= 16
//  SBOX_LAT  2         cycles from o_share_valid to matching i_sbox_shares; >= 1
//  SEED      16'hACE1  LFSR reset value; must be nonzero
// PORTS
//  i_clk          in   1               clock, posedge
//  i_rst          in   1               synchronous reset, active-high
//  i_valid        in   1               input nibble valid
//  o_ready        out  1               feeder can accept i_data
//  i_data         in   DATA_W          unmasked input nibble
//  i_seed_load    in   1               load i_seed into LFSR this cycle
//  i_seed         in   16              LFSR seed value
//  o_shares       out  NSHARES*DATA_W  share j at [j*DATA_W +: DATA_W], to S-box share regs
//  o_share_valid  out  1               o_shares valid, exactly one cycle per transaction
//  i_sbox_shares  in   NSHARES*DATA_W  S-box output shares returned from pipeline
//  o_valid        out  1               o_data valid, held until accepted
//  o_data         out  DATA_W          recombined (unmasked) S-box result
//  i_ready        in   1               downstream accepts o_data
// BEHAVIOUR
//  - Reset, as a single synchronous priority over everything else:
//    - Outputs: o_shares=0, o_share_valid=0, o_valid=0, o_data=0.
//    - Internal: FSM=IDLE, wait counter=0, LFSR=SEED.
//    - Reset mid-transaction aborts it; no output is produced for it.
//  - LFSR, Fibonacci form:
//    - Steps every cycle: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
//    - i_seed_load has priority over stepping and is honoured in any FSM state.
//    - i_seed==0 loads SEED instead (no lock-up).
//  - FSM IDLE -> WAIT -> HOLD -> IDLE. o_ready = (state==IDLE), driven combinationally from the state.
//  - IDLE, on accept (i_valid & o_ready) in cycle t:
//    - Random shares are taken from the current-cycle LFSR: share j (1..NSHARES-1) = lfsr[(j-1)*DATA_W +: DATA_W].
//    - Share 0 = i_data ^ XOR of shares 1..NSHARES-1.
//    - The shares are registered; o_share_valid=1 in cycle t+1 only.
//    - Go to WAIT with counter = SBOX_LAT.
//    - If i_seed_load arrives in the same cycle, masks use the pre-load LFSR value.
//  - WAIT:
//    - Counter decrements each cycle.
//    - In cycle t+1+SBOX_LAT: o_data <= XOR of all i_sbox_shares, then go to HOLD.
//    - o_shares keeps its last value; o_share_valid=0.
//  - HOLD:
//    - o_valid=1 from cycle t+2+SBOX_LAT; o_data stable while o_valid & !i_ready.
//    - On i_valid... no: on o_valid & i_ready -> IDLE, and o_valid=0 next cycle.
//    - No new accept in the handshake cycle; minimum spacing between accepts is SBOX_LAT+3 cycles.
//  - i_valid/i_data are ignored while o_ready=0; the sender must hold them.
//  - Total latency from accept to first o_valid cycle: SBOX_LAT+2.
// CONFIGURATION
//  - SHARE_FEEDER_NORAND_EN defined (functional debug only, NOT side-channel secure):
//    - All random shares are forced to 0; share 0 = i_data.
//    - The LFSR still runs and loads.
//  - SHARE_FEEDER_NORAND_EN undefined (default): masking exactly as in BEHAVIOUR.
// TESTING (bench loops o_shares back to i_sbox_shares through a SBOX_LAT-stage identity delay unless stated)
//  1. Reset, then accept i_data=4'h5 in the first post-reset cycle (DATA_W=4, NSHARES=2, SBOX_LAT=2):
//     -> o_shares={4'h1,4'h4} with o_share_valid=1 at t+1; o_valid=1 with o_data=4'h5 at t+4.
//  2. Hold i_ready=0 for 5 cycles during HOLD -> o_valid stays 1, o_data stays 4'h5,
//     o_ready stays 0, and a pending i_valid is not accepted.
//  3. i_seed_load=1 with i_seed=16'h0000, then accept in the next cycle
//     -> random share = SEED-derived value 4'h1; i_seed=16'h1234 instead -> random share 4'h4.
//  4. Assert i_rst during WAIT -> next cycle o_valid=0, o_share_valid=0, o_ready=1,
//     and no o_valid ever appears for the aborted nibble.
//  5. Sweep all 16 nibbles back-to-back, holding i_ready=1:
//     -> each o_data equals its input, each XOR(o_shares) equals its input, accept spacing = 5 cycles.
//  6. Build with SHARE_FEEDER_NORAND_EN and accept 4'hA -> o_shares={4'h0,4'hA}; o_data=4'hA.

Source files
------------

// File: rtl/share_mask_feeder.sv
// share_mask_feeder: splits an unmasked nibble into Boolean shares with an internal
// 16-bit Fibonacci LFSR, presents them registered to the masked S-box share registers,
// waits the pipeline latency, XOR-recombines the returned shares and hands the result
// downstream over valid/ready. One transaction in flight at a time.
// Build option: SHARE_FEEDER_NORAND_EN forces all random shares to zero (debug only,
// not side-channel secure); the LFSR keeps running and loading.
module share_mask_feeder #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned NSHARES  = 2,
    parameter int unsigned SBOX_LAT = 2,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [DATA_W-1:0]         i_data,
    input  logic                      i_seed_load,
    input  logic [15:0]               i_seed,
    output logic [NSHARES*DATA_W-1:0] o_shares,
    output logic                      o_share_valid,
    input  logic [NSHARES*DATA_W-1:0] i_sbox_shares,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_data,
    input  logic                      i_ready
);

    localparam int unsigned SW   = NSHARES * DATA_W;
    localparam int unsigned CntW = (SBOX_LAT < 2) ? 1 : $clog2(SBOX_LAT + 1);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [SW-1:0]     shares_q, shares_d;
    logic              share_valid_q, share_valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mask_xor;
    logic [DATA_W-1:0] ret_xor;
    logic              accept;
    logic              ret_capture;

    assign accept      = i_valid & o_ready;
    assign ret_capture = (state_q == StWait) && (cnt_q == '0);

    // LFSR next value: seed load beats stepping; a zero seed falls back to SEED.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (i_seed_load) begin
            lfsr_d = (i_seed == 16'h0000) ? SEED : i_seed;
        end
    end

    // Share split on accept; masks come from the current (pre-load) LFSR value.
    always_comb begin
        shares_d      = shares_q;
        share_valid_d = accept;
        mask_xor      = '0;
        if (accept) begin
            for (int j = 1; j < NSHARES; j++) begin
`ifdef SHARE_FEEDER_NORAND_EN
                shares_d[j*DATA_W +: DATA_W] = '0;
`else
                shares_d[j*DATA_W +: DATA_W] = lfsr_q[(j-1)*DATA_W +: DATA_W];
`endif
                mask_xor = mask_xor ^ shares_d[j*DATA_W +: DATA_W];
            end
            shares_d[DATA_W-1:0] = i_data ^ mask_xor;
        end
    end

    // Recombination of the shares returned by the S-box pipeline.
    always_comb begin
        ret_xor = '0;
        for (int j = 0; j < NSHARES; j++) begin
            ret_xor = ret_xor ^ i_sbox_shares[j*DATA_W +: DATA_W];
        end
        data_d = ret_capture ? ret_xor : data_q;
    end

    // FSM state register and latency counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: IDLE -> WAIT (SBOX_LAT+1 cycles) -> HOLD until accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    state_d = StWait;
                    cnt_d   = CntW'(SBOX_LAT);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs decoded from the state.
    always_comb begin
        o_ready = (state_q == StIdle);
        o_valid = (state_q == StHold);
    end

    // Datapath registers: LFSR, share outputs, recombined result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q        <= SEED;
            shares_q      <= '0;
            share_valid_q <= 1'b0;
            data_q        <= '0;
        end else begin
            lfsr_q        <= lfsr_d;
            shares_q      <= shares_d;
            share_valid_q <= share_valid_d;
            data_q        <= data_d;
        end
    end

    assign o_shares      = shares_q;
    assign o_share_valid = share_valid_q;
    assign o_data        = data_q;

endmodule

// File: tb/tb_share_mask_feeder.sv
// Self-checking bench for share_mask_feeder (DATA_W=4, NSHARES=2, SBOX_LAT=2).
// o_shares is looped back to i_sbox_shares through an SBOX_LAT-stage delay line.
module tb_share_mask_feeder;

    localparam int          L    = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        i_clk, i_rst, i_valid, o_ready, i_seed_load, o_share_valid;
    logic        o_valid, i_ready;
    logic [3:0]  i_data, o_data;
    logic [15:0] i_seed;
    logic [7:0]  o_shares, i_sbox_shares;
    logic [7:0]  dly [L];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] m_lfsr;

    share_mask_feeder #(
        .DATA_W   (4),
        .NSHARES  (2),
        .SBOX_LAT (L),
        .SEED     (SEED)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .i_seed_load   (i_seed_load),
        .i_seed        (i_seed),
        .o_shares      (o_shares),
        .o_share_valid (o_share_valid),
        .i_sbox_shares (i_sbox_shares),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .i_ready       (i_ready)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Identity S-box pipeline of L stages.
    always @(posedge i_clk) begin
        dly[0] <= o_shares;
        for (int k = 1; k < L; k++) dly[k] <= dly[k-1];
    end
    assign i_sbox_shares = dly[L-1];

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [3:0] mask_of(input logic [15:0] l);
`ifdef SHARE_FEEDER_NORAND_EN
        return 4'h0;
`else
        return l[3:0];
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance the reference LFSR from the inputs applied this cycle.
    task automatic step();
        logic [15:0] nxt;
        if (i_rst)            nxt = SEED;
        else if (i_seed_load) nxt = (i_seed == 16'h0000) ? SEED : i_seed;
        else                  nxt = lfsr_next(m_lfsr);
        @(posedge i_clk);
        m_lfsr = nxt;
        cyc++;
        #1;
    endtask

    // Full transaction: accept, check shares, fixed latency, hold, handshake.
    task automatic do_txn(input logic [3:0] d, input int hold,
                          output logic [7:0] sh, output int acc_cyc);
        logic [3:0] r;
        logic [7:0] exp_sh;
        r      = mask_of(m_lfsr);
        exp_sh = {r, d ^ r};
        chk("ready_before_accept", 16'(o_ready), 16'd1);
        i_valid = 1'b1;
        i_data  = d;
        acc_cyc = cyc;
        step();
        i_valid     = 1'b0;
        i_seed_load = 1'b0;
        sh          = o_shares;
        chk("share_valid", 16'(o_share_valid), 16'd1);
        chk("shares", 16'(o_shares), 16'(exp_sh));
        chk("share_xor", 16'(o_shares[7:4] ^ o_shares[3:0]), 16'(d));
        chk("ready_busy", 16'(o_ready), 16'd0);
        for (int k = 1; k <= L + 1; k++) begin
            step();
            chk("share_valid_low", 16'(o_share_valid), 16'd0);
            chk("valid_latency", 16'(o_valid), (k == L + 1) ? 16'd1 : 16'd0);
        end
        chk("o_data", 16'(o_data), 16'(d));
        for (int k = 0; k < hold; k++) begin
            i_ready = 1'b0;
            i_valid = 1'b1;
            i_data  = ~d;
            step();
            chk("hold_valid", 16'(o_valid), 16'd1);
            chk("hold_data", 16'(o_data), 16'(d));
            chk("hold_ready", 16'(o_ready), 16'd0);
            chk("hold_no_accept", 16'(o_share_valid), 16'd0);
        end
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        chk("valid_drop", 16'(o_valid), 16'd0);
        chk("ready_back", 16'(o_ready), 16'd1);
        chk("no_accept_in_handshake", 16'(o_share_valid), 16'd0);
    endtask

    initial begin
        logic [7:0] sh;
        int         ac;
        int         prev;

        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_data      = 4'h0;
        i_seed_load = 1'b0;
        i_seed      = 16'h0000;
        i_ready     = 1'b1;
        step();
        step();
        chk("rst_shares", 16'(o_shares), 16'h0000);
        chk("rst_share_valid", 16'(o_share_valid), 16'd0);
        chk("rst_valid", 16'(o_valid), 16'd0);
        chk("rst_data", 16'(o_data), 16'h0000);
        chk("rst_ready", 16'(o_ready), 16'd1);
        i_rst = 1'b0;

        // First post-reset cycle accept of 5, then 5 cycles of back-pressure.
        do_txn(4'h5, 5, sh, ac);
`ifndef SHARE_FEEDER_NORAND_EN
        chk("t1_shares", 16'(sh), 16'h0014);
`endif

        // Zero seed falls back to SEED; explicit seed takes effect.
        i_seed_load = 1'b1;
        i_seed      = 16'h0000;
        step();
        i_seed_load = 1'b0;
        do_txn(4'h3, 0, sh, ac);
`ifndef SHARE_FEEDER_NORAND_EN
        chk("seed0_mask", 16'(sh[7:4]), 16'h0001);
`endif
        i_seed_load = 1'b1;
        i_seed      = 16'h1234;
        step();
        i_seed_load = 1'b0;
        do_txn(4'h9, 0, sh, ac);
`ifndef SHARE_FEEDER_NORAND_EN
        chk("seed1234_mask", 16'(sh[7:4]), 16'h0004);
`endif

        // Reset during WAIT aborts the transaction.
        i_valid = 1'b1;
        i_data  = 4'h7;
        step();
        i_valid = 1'b0;
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("abort_valid", 16'(o_valid), 16'd0);
        chk("abort_share_valid", 16'(o_share_valid), 16'd0);
        chk("abort_ready", 16'(o_ready), 16'd1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("abort_no_valid", 16'(o_valid), 16'd0);
        end

        // All 16 nibbles back to back with i_ready held high.
        i_ready = 1'b1;
        prev    = 0;
        for (int d = 0; d < 16; d++) begin
            do_txn(4'(d), 0, sh, ac);
            if (d > 0) chk("accept_spacing", 16'(ac - prev), 16'(L + 3));
            prev = ac;
        end

`ifdef SHARE_FEEDER_NORAND_EN
        do_txn(4'hA, 0, sh, ac);
        chk("norand_shares", 16'(sh), 16'h000A);
`endif

        // Randomized transactions, seed loads, gaps and back-pressure.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3, 0) == 0) begin
                i_seed_load = 1'b1;
                i_seed      = ($urandom_range(3, 0) == 0) ? 16'h0000 : 16'($urandom);
                step();
                i_seed_load = 1'b0;
            end
            for (int g = $urandom_range(2, 0); g > 0; g--) step();
            if ($urandom_range(3, 0) == 0) begin
                i_seed_load = 1'b1;
                i_seed      = 16'($urandom);
            end
            do_txn(4'($urandom_range(15, 0)), $urandom_range(3, 0), sh, ac);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
